program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 18 +
 rtl/program_loader_word_assembler.sv | 30 +++
 rtl/program_loader.sv | 94 +++++++++
 tb/tb_program_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state codes and stream field geometry.
package program_loader_pkg;

    localparam int unsigned FIELD_BYTES = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_LEN   = 3'd0;
    localparam state_t ST_DATA  = 3'd1;
    localparam state_t ST_CSUM  = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_ERROR = 3'd4;

    function automatic logic state_accepts_bytes(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words; word_valid pulses with the final byte's handshake.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  index;
    logic [23:0] partial;

    always_ff @(posedge clk) begin
        if (reset) begin
            index   <= '0;
            partial <= '0;
        end else if (take) begin
            index   <= index + 2'd1;
            partial <= {byte_data, partial[23:8]};
        end
    end

    // The last byte is combined directly so the word is usable on its own handshake edge.
    assign word       = {byte_data, partial};
    assign word_valid = take && (index == 2'(FIELD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length/data/checksum byte stream and writes it into instruction memory.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        imem_write_enable_o,
    output logic [31:0] imem_address_o,
    output logic [31:0] imem_data_o,
    output logic        core_reset_o,
    output logic        done_o,
    output logic        error_o
);

    state_t      state;
    logic        armed;
    logic [31:0] word_count;
    logic [31:0] length;
    logic [31:0] checksum;
    logic        take;
    logic        word_valid;
    logic [31:0] word;

    // armed keeps ready low during reset and releases it one cycle later.
    assign byte_ready_o = armed && state_accepts_bytes(state);
    assign take         = byte_valid_i && byte_ready_o;

    word_assembler assembler (
        .clk        (clk_i),
        .reset      (reset_i),
        .take       (take),
        .byte_data  (byte_data_i),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state               <= ST_LEN;
            armed               <= 1'b0;
            word_count          <= '0;
            length              <= '0;
            checksum            <= '0;
            imem_write_enable_o <= 1'b0;
            imem_address_o      <= BASE_ADDR;
            imem_data_o         <= '0;
        end else begin
            armed               <= 1'b1;
            imem_write_enable_o <= 1'b0;
            if (word_valid) begin
                case (state)
                    ST_LEN: begin
                        length     <= word;
                        word_count <= '0;
                        checksum   <= '0;
                        if (word == '0) begin
                            state <= ST_CSUM;
                        end else if (word > 32'(MEM_WORDS)) begin
                            state <= ST_ERROR;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        imem_write_enable_o <= 1'b1;
                        imem_data_o         <= word;
                        imem_address_o      <= BASE_ADDR + (word_count << 2);
                        checksum            <= checksum ^ word;
                        word_count          <= word_count + 32'd1;
                        if (word_count + 32'd1 == length) begin
                            state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        state <= (word == checksum) ? ST_DONE : ST_ERROR;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign core_reset_o = (state != ST_DONE);
    assign done_o       = (state == ST_DONE);
    assign error_o      = (state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader with a stream-level reference model and directed image cases.
module tb_program_loader;

    localparam int unsigned MW = 64;
    localparam logic [31:0] BA = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o;
    logic        imem_write_enable_o;
    logic [31:0] imem_address_o;
    logic [31:0] imem_data_o;
    logic        core_reset_o;
    logic        done_o;
    logic        error_o;

    program_loader #(.MEM_WORDS(MW), .BASE_ADDR(BA)) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .byte_valid_i        (byte_valid_i),
        .byte_data_i         (byte_data_i),
        .byte_ready_o        (byte_ready_o),
        .imem_write_enable_o (imem_write_enable_o),
        .imem_address_o      (imem_address_o),
        .imem_data_o         (imem_data_o),
        .core_reset_o        (core_reset_o),
        .done_o              (done_o),
        .error_o             (error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  img[$];
    logic [7:0]  nb[$];
    logic [31:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    int          accepted = 0;
    bit          armed_m = 1'b0;
    bit          started = 1'b0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = BA;
    logic [31:0] exp_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] field(input int idx);
        if (idx + 3 >= img.size()) return '0;
        return {img[idx+3], img[idx+2], img[idx+1], img[idx]};
    endfunction

    // 0 = still loading, 1 = image accepted, 2 = image rejected, given bytes accepted so far
    function automatic int phase(input int acc);
        longint n;
        logic [31:0] x;
        if (acc < 4) return 0;
        n = longint'(field(0));
        if (n > longint'(MW)) return 2;
        if (longint'(acc) < 8 + 4 * n) return 0;
        x = '0;
        for (int k = 0; k < int'(n); k++) x = x ^ field(4 + 4 * k);
        return (field(4 + 4 * int'(n)) == x) ? 1 : 2;
    endfunction

    always @(posedge clk) begin
        if (reset_i) begin
            accepted = 0;
            armed_m  = 1'b0;
            exp_we   = 1'b0;
            exp_addr = BA;
            exp_data = '0;
            started  = 1'b1;
        end else begin
            exp_we = 1'b0;
            if (byte_valid_i && armed_m && phase(accepted) == 0) begin
                accepted++;
                if (accepted % 4 == 0 && accepted > 4 &&
                    longint'(accepted) <= 4 + 4 * longint'(field(0))) begin
                    exp_we   = 1'b1;
                    exp_addr = BA + 32'(4 * (accepted / 4 - 2));
                    exp_data = field(accepted - 4);
                end
            end
            armed_m = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int p;
            p = phase(accepted);
            chk("ready", 32'(byte_ready_o), 32'(armed_m && p == 0));
            chk("done", 32'(done_o), 32'(p == 1));
            chk("error", 32'(error_o), 32'(p == 2));
            chk("core_reset", 32'(core_reset_o), 32'(p != 1));
            chk("write_enable", 32'(imem_write_enable_o), 32'(exp_we));
            chk("address", imem_address_o, exp_addr);
            chk("data", imem_data_o, exp_data);
            if (imem_write_enable_o === 1'b1) begin
                wlog_a.push_back(imem_address_o);
                wlog_d.push_back(imem_data_o);
            end
        end
    end

    task automatic push32(input logic [31:0] w);
        for (int b = 0; b < 4; b++) nb.push_back(8'(w >> (8 * b)));
    endtask

    task automatic reset_load();
        @(posedge clk); #1;
        reset_i      = 1'b1;
        byte_valid_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        img = nb;
        wlog_a.delete();
        wlog_d.delete();
        reset_i = 1'b0;
    endtask

    // gap_pct < 0 means strictly alternate valid high/low each cycle
    task automatic send(input int count, input int gap_pct);
        for (int i = 0; i < count; i++) begin
            int t;
            if (gap_pct < 0) begin
                byte_valid_i = 1'b0;
                @(posedge clk); #1;
            end else begin
                for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
                    byte_valid_i = 1'b0;
                    byte_data_i  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            byte_valid_i = 1'b1;
            byte_data_i  = img[i];
            t = 0;
            while (accepted <= i && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
            checks++;
            if (accepted <= i) begin
                errors++;
                $display("FAIL handshake_timeout actual %0d required %0d", accepted, i + 1);
                byte_valid_i = 1'b0;
                return;
            end
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic poke(input int n);
        repeat (n) begin
            byte_valid_i = 1'b1;
            byte_data_i  = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);

        // Two-word image with correct XOR checksum
        nb.delete(); push32(32'd2); push32(32'h00500093); push32(32'h00A00113); push32(32'h00F00180);
        reset_load(); send(nb.size(), 30); repeat (3) @(posedge clk); #1;
        chk("t1_writes", 32'(wlog_a.size()), 32'd2);
        if (wlog_a.size() == 2) begin
            chk("t1_addr0", wlog_a[0], 32'h0);
            chk("t1_data0", wlog_d[0], 32'h00500093);
            chk("t1_addr1", wlog_a[1], 32'h4);
            chk("t1_data1", wlog_d[1], 32'h00A00113);
        end
        chk("t1_done", 32'(done_o), 32'd1);
        chk("t1_core_reset", 32'(core_reset_o), 32'd0);
        poke(3); #1;
        chk("t1_done_held", 32'(done_o), 32'd1);

        // Same image, bad checksums
        nb.delete(); push32(32'd2); push32(32'h00500093); push32(32'h00A00113); push32(32'h00000000);
        reset_load(); send(nb.size(), 0); repeat (2) @(posedge clk); #1;
        chk("t2_error", 32'(error_o), 32'd1);
        chk("t2_done", 32'(done_o), 32'd0);
        chk("t2_core_reset", 32'(core_reset_o), 32'd1);
        nb.delete(); push32(32'd2); push32(32'h00500093); push32(32'h00A00113); push32(32'h00A00190);
        reset_load(); send(nb.size(), 10); repeat (2) @(posedge clk); #1;
        chk("t2b_error", 32'(error_o), 32'd1);

        // Oversized length rejected right after the fourth length byte
        nb.delete(); push32(32'(MW + 1));
        reset_load(); send(4, 20);
        chk("t3_error_now", 32'(error_o), 32'd1);
        chk("t3_ready", 32'(byte_ready_o), 32'd0);
        poke(5); repeat (2) @(posedge clk); #1;
        chk("t3_writes", 32'(wlog_a.size()), 32'd0);

        // Empty image
        nb.delete(); push32(32'd0); push32(32'd0);
        reset_load(); send(nb.size(), 0); repeat (2) @(posedge clk); #1;
        chk("t4_done", 32'(done_o), 32'd1);
        chk("t4_writes", 32'(wlog_a.size()), 32'd0);

        // One word with alternating valid
        nb.delete(); push32(32'd1); push32(32'hDEADBEEF); push32(32'hDEADBEEF);
        reset_load(); send(nb.size(), -1); repeat (2) @(posedge clk); #1;
        chk("t5_writes", 32'(wlog_a.size()), 32'd1);
        if (wlog_a.size() == 1) begin
            chk("t5_addr", wlog_a[0], BA);
            chk("t5_data", wlog_d[0], 32'hDEADBEEF);
        end
        chk("t5_done", 32'(done_o), 32'd1);

        // Abort mid-word, then reload a fresh image
        nb.delete(); push32(32'd3); push32(32'hAAAAAAAA); push32(32'hBBBBBBBB); push32(32'hCCCCCCCC); push32(32'h0);
        reset_load(); send(6, 0);
        nb.delete(); push32(32'd2); push32(32'h11111111); push32(32'h22222222); push32(32'h33333333);
        reset_load(); send(nb.size(), 25); repeat (2) @(posedge clk); #1;
        chk("t6_writes", 32'(wlog_a.size()), 32'd2);
        if (wlog_a.size() == 2) begin
            chk("t6_data0", wlog_d[0], 32'h11111111);
            chk("t6_data1", wlog_d[1], 32'h22222222);
        end
        chk("t6_done", 32'(done_o), 32'd1);

        // Random images, judged cycle by cycle against the model
        for (int r = 0; r < 12; r++) begin
            int unsigned n;
            logic [31:0] x;
            bit oversize;
            oversize = ($urandom_range(7) == 0);
            n = oversize ? MW + 1 + $urandom_range(1000) : $urandom_range(MW);
            nb.delete();
            push32(32'(n));
            if (!oversize) begin
                x = '0;
                for (int k = 0; k < int'(n); k++) begin
                    logic [31:0] w;
                    w = $urandom;
                    x = x ^ w;
                    push32(w);
                end
                if ($urandom_range(3) == 0) x = x ^ (32'd1 << $urandom_range(31));
                push32(x);
            end
            reset_load();
            send(nb.size(), int'($urandom_range(60)));
            repeat (3) @(posedge clk); #1;
            poke(2);
            if (!oversize) chk("rand_writes", 32'(wlog_a.size()), 32'(n));
            else           chk("rand_writes", 32'(wlog_a.size()), 32'd0);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
